// File: rtl/send_cmd_exec.sv
// Command sequence executor: walks the command RAM from a start address,
// streams each word over a ready/valid TX port with a programmable gap
// between words, and stops on a word flagged LAST (or after a full RAM lap).
module send_cmd_exec #(
  parameter int RAM_AW   = 6,
  parameter int DW       = 32,
  parameter int LAST_BIT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAM_AW-1:0] start_ram_addr,
  input  logic              send_cmd,
  input  logic [31:0]       send_ch_2_timer,
  output logic              ram_rd_en,
  output logic [RAM_AW-1:0] ram_rd_addr,
  input  logic [DW-1:0]     ram_rd_data,
  output logic [DW-1:0]     tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done,
  output logic              cmd_dropped,
  output logic              err_no_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  // Last word index of a maximum-length sequence (one full lap of the RAM)
  localparam logic [RAM_AW-1:0] CNT_MAX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [RAM_AW-1:0] addr;
  logic [31:0]       gap;
  logic [31:0]       gap_cnt;
  logic [RAM_AW-1:0] word_cnt;
  logic [DW-1:0]     tx_data_r;
  logic              tx_last_r;
  logic              forced_last;
  logic              cmd_dropped_r;
  logic              xfer;

  assign ram_rd_addr = addr;
  assign tx_data     = tx_data_r;
  assign tx_last     = tx_last_r;
  assign busy        = (state != S_IDLE);
  assign cmd_dropped = cmd_dropped_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state output strobes
  always_comb begin
    state_nxt   = state;
    ram_rd_en   = 1'b0;
    tx_valid    = 1'b0;
    done        = 1'b0;
    err_no_last = 1'b0;
    xfer        = 1'b0;
    case (state)
      S_IDLE: begin
        if (send_cmd) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        ram_rd_en = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          xfer = 1'b1;
          if (tx_last_r) begin
            state_nxt = S_DONE;
          end else if (gap != '0) begin
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt <= 32'd1) begin
          state_nxt = S_FETCH;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        err_no_last = forced_last;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequence context: start address/gap latch, word capture, address and gap counters
  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      gap         <= '0;
      gap_cnt     <= '0;
      word_cnt    <= '0;
      tx_data_r   <= '0;
      tx_last_r   <= 1'b0;
      forced_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (send_cmd) begin
            addr        <= start_ram_addr;
            gap         <= send_ch_2_timer;
            word_cnt    <= '0;
            forced_last <= 1'b0;
          end
        end
        S_WAIT: begin
          tx_data_r   <= ram_rd_data;
          tx_last_r   <= ram_rd_data[LAST_BIT] || (word_cnt == CNT_MAX);
          forced_last <= !ram_rd_data[LAST_BIT] && (word_cnt == CNT_MAX);
        end
        S_SEND: begin
          if (xfer && !tx_last_r) begin
            addr     <= addr + 1'b1;
            word_cnt <= word_cnt + 1'b1;
            gap_cnt  <= gap;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Flag a start request that arrives while a sequence is still running
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_dropped_r <= 1'b0;
    end else begin
      cmd_dropped_r <= send_cmd && (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_send_cmd_exec.sv
// Self-checking bench for send_cmd_exec: a RAM model answers reads one cycle
// after ram_rd_en, a scoreboard queue holds the words each scenario expects on
// the TX port, and each scenario task checks latencies from logged event cycles.
module tb_send_cmd_exec;
  localparam int RAM_AW = 6;
  localparam int DW     = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [RAM_AW-1:0] start_ram_addr = '0;
  logic              send_cmd = 1'b0;
  logic [31:0]       send_ch_2_timer = '0;
  logic              ram_rd_en;
  logic [RAM_AW-1:0] ram_rd_addr;
  logic [DW-1:0]     ram_rd_data = '0;
  logic [DW-1:0]     tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              tx_last;
  logic              busy;
  logic              done;
  logic              cmd_dropped;
  logic              err_no_last;

  send_cmd_exec #(.RAM_AW(RAM_AW), .DW(DW), .LAST_BIT(31)) dut (
    .clk(clk),
    .rst(rst),
    .start_ram_addr(start_ram_addr),
    .send_cmd(send_cmd),
    .send_ch_2_timer(send_ch_2_timer),
    .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_last(tx_last),
    .busy(busy),
    .done(done),
    .cmd_dropped(cmd_dropped),
    .err_no_last(err_no_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:63];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] exp_word;
  int rd_cyc[$];
  int rd_addr[$];
  int vstart_cyc[$];
  int xfer_cyc[$];
  int done_cyc[$];
  int done_err[$];
  int drop_cyc[$];
  int busy_fall[$];

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_last  = 1'b0;
  logic          prev_busy  = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Monitor: logs DUT events per cycle and scores every TX transfer
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (ram_rd_en) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(int'(ram_rd_addr));
      end
      if (tx_valid && !prev_valid) vstart_cyc.push_back(cyc);
      if (tx_valid && prev_valid && !prev_ready) begin
        n_checks++;
        if (tx_data !== prev_data || tx_last !== prev_last) begin
          n_fail++;
          $display("[TB] FAIL hold_stable: got data=%h last=%0d required data=%h last=%0d",
                   tx_data, tx_last, prev_data, prev_last);
        end
      end
      if (tx_valid && tx_ready) begin
        n_checks++;
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL scoreboard: got unexpected word data=%h last=%0d at cycle %0d",
                   tx_data, tx_last, cyc);
        end else begin
          exp_word = exp_q.pop_front();
          if ({tx_last, tx_data} !== exp_word) begin
            n_fail++;
            $display("[TB] FAIL scoreboard: got data=%h last=%0d required data=%h last=%0d",
                     tx_data, tx_last, exp_word[DW-1:0], exp_word[DW]);
          end
        end
      end
      if (done) begin
        done_cyc.push_back(cyc);
        done_err.push_back(int'(err_no_last));
      end
      if (cmd_dropped) drop_cyc.push_back(cyc);
      if (!busy && prev_busy) busy_fall.push_back(cyc);
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
      prev_busy  = busy;
    end
  end

  task automatic clear_logs();
    exp_q.delete();
    rd_cyc.delete();
    rd_addr.delete();
    vstart_cyc.delete();
    xfer_cyc.delete();
    done_cyc.delete();
    done_err.delete();
    drop_cyc.delete();
    busy_fall.delete();
  endtask

  task automatic start_seq(input logic [RAM_AW-1:0] a, input logic [31:0] g, output int n);
    @(posedge clk); #1;
    start_ram_addr  = a;
    send_ch_2_timer = g;
    send_cmd        = 1'b1;
    n               = cyc;
    @(posedge clk); #1;
    send_cmd = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cyc.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send_cmd = 1'b1;
    start_ram_addr = 6'd7;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, tx_valid, done, ram_rd_en, tx_last, cmd_dropped, err_no_last} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b required 0000000",
               {busy, tx_valid, done, ram_rd_en, tx_last, cmd_dropped, err_no_last});
    end
    n_checks++;
    if (tx_data !== '0 || ram_rd_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got data=%h addr=%0d required 0/0", tx_data, ram_rd_addr);
    end
    rst = 1'b0;
    send_cmd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (rd_cyc.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_wins: got reads=%0d busy=%0d required 0/0", rd_cyc.size(), busy);
    end
  endtask

  task automatic test_basic();
    int n;
    bit ok;
    clear_logs();
    ram[5] = 32'h0000_0011;
    ram[6] = 32'h8000_0022;
    tx_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_0011});
    exp_q.push_back({1'b1, 32'h8000_0022});
    start_seq(6'd5, 32'd0, n);
    wait_idle(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL basic_timeout: got no done required done"); end
    n_checks++;
    if (at(rd_cyc, 0) !== n + 1 || at(rd_addr, 0) !== 5) begin
      n_fail++;
      $display("[TB] FAIL basic_first_read: got cyc=%0d addr=%0d required cyc=%0d addr=5",
               at(rd_cyc, 0) - n, at(rd_addr, 0), 1);
    end
    n_checks++;
    if (at(vstart_cyc, 0) !== n + 3) begin
      n_fail++;
      $display("[TB] FAIL basic_first_valid: got +%0d required +3", at(vstart_cyc, 0) - n);
    end
    n_checks++;
    if (at(xfer_cyc, 1) !== n + 6) begin
      n_fail++;
      $display("[TB] FAIL basic_second_valid: got +%0d required +6", at(xfer_cyc, 1) - n);
    end
    n_checks++;
    if (at(done_cyc, 0) !== n + 7 || done_cyc.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL basic_done: got +%0d (count %0d) required +7 (count 1)",
               at(done_cyc, 0) - n, done_cyc.size());
    end
    n_checks++;
    if (at(busy_fall, 0) !== n + 8) begin
      n_fail++;
      $display("[TB] FAIL basic_busy_drop: got +%0d required +8", at(busy_fall, 0) - n);
    end
    n_checks++;
    if (exp_q.size() != 0 || at(done_err, 0) !== 0) begin
      n_fail++;
      $display("[TB] FAIL basic_complete: got pending=%0d err=%0d required 0/0",
               exp_q.size(), at(done_err, 0));
    end
  endtask

  task automatic test_gap_backpressure();
    int n;
    bit ok;
    clear_logs();
    tx_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_0011});
    exp_q.push_back({1'b1, 32'h8000_0022});
    start_seq(6'd5, 32'd4, n);
    send_ch_2_timer = 32'd0;
    wait_until(n + 6);
    tx_ready = 1'b1;
    wait_idle(80, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL gap_timeout: got no done required done"); end
    n_checks++;
    if (at(vstart_cyc, 0) !== n + 3 || at(xfer_cyc, 0) !== n + 6) begin
      n_fail++;
      $display("[TB] FAIL gap_first_hold: got valid +%0d xfer +%0d required +3/+6",
               at(vstart_cyc, 0) - n, at(xfer_cyc, 0) - n);
    end
    n_checks++;
    if (at(xfer_cyc, 1) !== n + 13) begin
      n_fail++;
      $display("[TB] FAIL gap_second_valid: got +%0d required +13", at(xfer_cyc, 1) - n);
    end
    n_checks++;
    if (at(done_cyc, 0) !== n + 14 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL gap_done: got +%0d pending=%0d required +14 pending=0",
               at(done_cyc, 0) - n, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int n;
    bit ok;
    clear_logs();
    ram[63] = 32'h0000_0001;
    ram[0]  = 32'h8000_0002;
    exp_q.push_back({1'b0, 32'h0000_0001});
    exp_q.push_back({1'b1, 32'h8000_0002});
    start_seq(6'd63, 32'd2, n);
    wait_idle(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL wrap_timeout: got no done required done"); end
    n_checks++;
    if (at(rd_addr, 0) !== 63 || at(rd_addr, 1) !== 0 || rd_addr.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL wrap_addr: got %0d,%0d (count %0d) required 63,0 (count 2)",
               at(rd_addr, 0), at(rd_addr, 1), rd_addr.size());
    end
    n_checks++;
    if (at(xfer_cyc, 1) !== n + 8 || xfer_cyc.size() != 2 || done_cyc.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL wrap_words: got second +%0d words=%0d dones=%0d required +8/2/1",
               at(xfer_cyc, 1) - n, xfer_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_busy_collision();
    int n;
    clear_logs();
    ram[10] = 32'h0000_000A;
    ram[11] = 32'h0000_000B;
    ram[12] = 32'h8000_000C;
    exp_q.push_back({1'b0, 32'h0000_000A});
    exp_q.push_back({1'b0, 32'h0000_000B});
    exp_q.push_back({1'b1, 32'h8000_000C});
    start_seq(6'd10, 32'd3, n);
    wait_until(n + 5);
    start_ram_addr  = 6'd20;
    send_ch_2_timer = 32'd0;
    send_cmd        = 1'b1;
    @(posedge clk); #1;
    send_cmd = 1'b0;
    wait_until(n + 16);
    start_ram_addr = 6'd30;
    send_cmd       = 1'b1;
    @(posedge clk); #1;
    send_cmd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (at(drop_cyc, 0) !== n + 6 || at(drop_cyc, 1) !== n + 17 || drop_cyc.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL busy_dropped: got +%0d,+%0d (count %0d) required +6,+17 (count 2)",
               at(drop_cyc, 0) - n, at(drop_cyc, 1) - n, drop_cyc.size());
    end
    n_checks++;
    if (at(rd_addr, 1) !== 11 || at(rd_addr, 2) !== 12 || rd_addr.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL busy_addr: got %0d,%0d (count %0d) required 11,12 (count 3)",
               at(rd_addr, 1), at(rd_addr, 2), rd_addr.size());
    end
    n_checks++;
    if (at(xfer_cyc, 1) !== n + 9 || at(xfer_cyc, 2) !== n + 15) begin
      n_fail++;
      $display("[TB] FAIL busy_gap: got +%0d,+%0d required +9,+15",
               at(xfer_cyc, 1) - n, at(xfer_cyc, 2) - n);
    end
    n_checks++;
    if (done_cyc.size() != 1 || at(done_cyc, 0) !== n + 16 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_single_done: got dones=%0d at +%0d busy=%0d required 1 at +16 busy=0",
               done_cyc.size(), at(done_cyc, 0) - n, busy);
    end
  endtask

  task automatic test_no_last();
    int n;
    bit ok;
    clear_logs();
    for (int i = 0; i < 64; i++) begin
      ram[i] = 32'h0000_0100 + 32'(i);
      exp_q.push_back({(i == 63), 32'h0000_0100 + 32'(i)});
    end
    start_seq(6'd0, 32'd0, n);
    wait_idle(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL nolast_timeout: got no done required done"); end
    n_checks++;
    if (rd_cyc.size() != 64 || xfer_cyc.size() != 64) begin
      n_fail++;
      $display("[TB] FAIL nolast_count: got reads=%0d words=%0d required 64/64",
               rd_cyc.size(), xfer_cyc.size());
    end
    n_checks++;
    if (done_cyc.size() != 1 || at(done_err, 0) !== 1) begin
      n_fail++;
      $display("[TB] FAIL nolast_err: got dones=%0d err=%0d required 1/1",
               done_cyc.size(), at(done_err, 0));
    end
    n_checks++;
    if (at(done_cyc, 0) !== at(xfer_cyc, 63) + 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL nolast_done_time: got %0d pending=%0d required %0d pending=0",
               at(done_cyc, 0), exp_q.size(), at(xfer_cyc, 63) + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    clear_logs();
    ram[20] = 32'h0000_0055;
    ram[40] = 32'h8000_0040;
    tx_ready = 1'b0;
    start_seq(6'd20, 32'd0, n);
    wait_until(n + 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: got valid=%0d busy=%0d done=%0d required 0/0/0",
               tx_valid, busy, done);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done_cyc.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_no_done: got %0d required 0", done_cyc.size());
    end
    clear_logs();
    tx_ready = 1'b1;
    exp_q.push_back({1'b1, 32'h8000_0040});
    start_seq(6'd40, 32'd0, n);
    wait_idle(60, ok);
    n_checks++;
    if (!ok || at(rd_addr, 0) !== 40 || xfer_cyc.size() != 1 || done_cyc.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL midreset_restart: got addr=%0d words=%0d dones=%0d required 40/1/1",
               at(rd_addr, 0), xfer_cyc.size(), done_cyc.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    test_reset();
    test_basic();
    test_gap_backpressure();
    test_wrap();
    test_busy_collision();
    test_no_last();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/send_cmd_exec.md
Name: send_cmd_exec

Overview:
- Executes a command sequence requested over the send_control interface.
- On a send_cmd pulse, reads 32-bit command words from the command RAM starting at start_ram_addr and streams them out on a ready/valid TX interface toward the SFP transmit path.
- Inserts the programmed ch_2_timer gap between words and stops on a word carrying the LAST flag.
- Sits between the PCIe register block, the command RAM read port and the SFP TX framer.

Parameters:
- RAM_AW, 6, command RAM address width; addresses wrap modulo 2^RAM_AW.
- DW, 32, command word / TX data width.
- LAST_BIT, 31, bit index of the end-of-sequence flag inside a command word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_ram_addr  in  RAM_AW  first command address; sampled with send_cmd.
- send_cmd  in  1  single-cycle start strobe.
- send_ch_2_timer  in  32  inter-word gap in clk cycles; sampled with send_cmd.
- ram_rd_en  out  1  RAM read strobe.
- ram_rd_addr  out  RAM_AW  RAM read address.
- ram_rd_data  in  DW  RAM read data; valid exactly 1 cycle after ram_rd_en.
- tx_data  out  DW  command word being sent.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the word.
- tx_last  out  1  final word of the sequence.
- busy  out  1  sequence in progress (not IDLE).
- done  out  1  single-cycle pulse at sequence end.
- cmd_dropped  out  1  single-cycle pulse: send_cmd arrived while busy.
- err_no_last  out  1  single-cycle pulse, coincident with done: 2^RAM_AW words sent without a LAST flag.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; address, gap and word counters 0. Applies mid-sequence too: tx_valid drops the next cycle and no done pulse is generated.
- States: IDLE, FETCH, WAIT, SEND, GAP, DONE.
- IDLE: when send_cmd=1, latch addr=start_ram_addr and gap=send_ch_2_timer, clear word count, go to FETCH.
- FETCH: ram_rd_en=1, ram_rd_addr=addr; go to WAIT.
- WAIT: capture ram_rd_data into the tx register; tx_last = data[LAST_BIT] OR (word count = 2^RAM_AW-1); go to SEND.
- SEND: tx_valid=1. tx_data and tx_last are held stable while tx_ready=0; there is no timeout. A transfer occurs when tx_valid and tx_ready are both 1. On transfer:
  - if tx_last: go to DONE;
  - else addr = addr+1 (mod 2^RAM_AW), count+1, and go to GAP if gap≠0, otherwise FETCH.
- GAP: count down from gap; stay exactly gap cycles, then go to FETCH.
- DONE: done=1 for one cycle; err_no_last=1 in the same cycle if the LAST flag was forced by the count; go to IDLE.
- Latency:
  - send_cmd sampled at cycle N gives ram_rd_en at N+1 and tx_valid at N+3.
  - After a transfer at cycle T, the next tx_valid is at T+3+gap.
  - After the final transfer at T, done is at T+1, and busy=0 from T+2.
- busy=1 in every state except IDLE.
- tx_data holds its last value while tx_valid=0 (don't-care for the sink).
- send_cmd while busy (including in the DONE cycle): ignored; cmd_dropped=1 on the next cycle. The latched address and gap are unaffected.
- send_cmd and rst asserted together: reset wins, no start.
- Gap changes while busy have no effect until the next start.
- Address wrap: addr 2^RAM_AW-1 increments to 0.
- Maximum sequence length is 2^RAM_AW words. The final word of a maximum-length sequence is sent with tx_last=1 even if its flag is 0.

Test Plan:
- Basic start: RAM[5]=0x0000_0011, RAM[6]=0x8000_0022; start_ram_addr=5, gap=0, tx_ready=1, send_cmd at cycle 10.
  - Required: ram_rd_en at 11 with addr 5; tx_valid at 13 with 0x11, tx_last=0.
  - Required: tx_valid at 16 with 0x8000_0022, tx_last=1; done at 17; busy=0 at 18.
- Gap and backpressure: same RAM, gap=4, tx_ready held low for 3 cycles after the first tx_valid.
  - Required: first word stable for 4 cycles; second tx_valid exactly 7 cycles after the first transfer.
- Wrap: start_ram_addr=63, RAM[63]=0x1, RAM[0]=0x8000_0002.
  - Required: read addresses 63 then 0; two words; done pulses.
- No-LAST: all RAM words with bit31=0, start=0.
  - Required: 64 words sent; 64th has tx_last=1; done and err_no_last pulse together; 65th read never issued.
- Busy collision: second send_cmd while in GAP.
  - Required: cmd_dropped pulse the next cycle; the sequence completes unchanged; only one done.
- Reset mid-op: rst for 1 cycle during SEND with tx_ready=0.
  - Required: the next cycle has tx_valid=0, busy=0, no done; a fresh send_cmd afterwards restarts from the newly sampled address.
